// File: rtl/pla_cube_pkg.sv
// Shared types and helpers for the programmable PLA cube engine.
package pla_cube_pkg;

   localparam int PLA_N_IN  = 20;
   localparam int PLA_N_OUT = 1;

   typedef struct packed {
      logic [PLA_N_IN-1:0]  care;
      logic [PLA_N_IN-1:0]  val;
      logic [PLA_N_OUT-1:0] omask;
   } cube_t;

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      DONE
   } state_e;

   function automatic int nbeats(input int n_cubes, input int lanes);
      return (n_cubes + lanes - 1) / lanes;
   endfunction

endpackage

// File: rtl/pla_cube_match.sv
// One lane of cube evaluation: passes the cube's output mask through when
// every cared literal agrees with the input vector.
module pla_cube_match
   import pla_cube_pkg::*;
#(
   parameter int N_IN  = PLA_N_IN,
   parameter int N_OUT = PLA_N_OUT
) (
   input  logic [N_IN-1:0]  x,
   input  logic [N_IN-1:0]  care,
   input  logic [N_IN-1:0]  val,
   input  logic [N_OUT-1:0] omask,
   output logic [N_OUT-1:0] hit
);

   logic match;

   assign match = (((x ^ val) & care) == '0);
   assign hit   = match ? omask : '0;

endmodule

// File: rtl/pla_cube_engine.sv
// Time-multiplexed sum-of-products evaluator with a reloadable cube table.
// Optional PLA_EXOR_EN adds per-output XOR accumulation (cfg_xor_mode port).
module pla_cube_engine
   import pla_cube_pkg::*;
#(
   parameter int N_IN    = PLA_N_IN,
   parameter int N_OUT   = PLA_N_OUT,
   parameter int N_CUBES = 32,
   parameter int LANES   = 4,
   localparam int AW     = (N_CUBES > 1) ? $clog2(N_CUBES) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [N_IN-1:0]  cfg_care,
   input  logic [N_IN-1:0]  cfg_val,
   input  logic [N_OUT-1:0] cfg_omask,
`ifdef PLA_EXOR_EN
   input  logic [N_OUT-1:0] cfg_xor_mode,
`endif
   output logic             cfg_err,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in_x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_OUT-1:0] out_y
);

   localparam int NBEATS = nbeats(N_CUBES, LANES);
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
   localparam logic [AW:0]   NCUBES_W  = (AW + 1)'(N_CUBES);

   state_e             state_q;
   state_e             state_d;
   logic [BW-1:0]      beat_q;
   logic [N_IN-1:0]    x_q;
   logic [N_OUT-1:0]   acc_q;
   logic [N_OUT-1:0]   acc_next;
   logic [N_OUT-1:0]   mode;
   logic               cfg_err_q;
   logic               cfg_fire;
   logic               addr_ok;
   logic               wr_en;

   logic [N_IN-1:0]    care_mem  [N_CUBES];
   logic [N_IN-1:0]    val_mem   [N_CUBES];
   logic [N_OUT-1:0]   omask_mem [N_CUBES];

   logic [N_IN-1:0]    lane_care  [LANES];
   logic [N_IN-1:0]    lane_val   [LANES];
   logic [N_OUT-1:0]   lane_omask [LANES];
   logic [N_OUT-1:0]   lane_hit   [LANES];
   logic [N_OUT-1:0]   or_red;
   logic [N_OUT-1:0]   xor_red;

   assign cfg_ready = (state_q == IDLE);
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_y     = (state_q == DONE) ? acc_q : '0;
   assign cfg_err   = cfg_err_q;

   assign cfg_fire  = cfg_valid & cfg_ready;
   assign addr_ok   = ({1'b0, cfg_addr} < NCUBES_W);
   assign wr_en     = cfg_fire & addr_ok;

   // Literal storage needs no reset: a cube is inert until its omask is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         care_mem[cfg_addr] <= cfg_care;
         val_mem[cfg_addr]  <= cfg_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CUBES; i++) begin
            omask_mem[i] <= '0;
         end
      end else if (wr_en) begin
         omask_mem[cfg_addr] <= cfg_omask;
      end
   end

`ifdef PLA_EXOR_EN
   logic [N_OUT-1:0] mode_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= '0;
      end else if (cfg_fire) begin
         mode_q <= cfg_xor_mode;
      end
   end

   assign mode = mode_q;
`else
   assign mode = '0;
`endif

   // Fetch this beat's slice of the table; indices past the table end read as disabled.
   always_comb begin
      logic [31:0] k;
      k = '0;
      for (int l = 0; l < LANES; l++) begin
         k             = 32'(beat_q) * 32'(LANES) + 32'(l);
         lane_care[l]  = care_mem[k[AW-1:0]];
         lane_val[l]   = val_mem[k[AW-1:0]];
         lane_omask[l] = (k < 32'(N_CUBES)) ? omask_mem[k[AW-1:0]] : '0;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      pla_cube_match #(
         .N_IN  (N_IN),
         .N_OUT (N_OUT)
      ) u_match (
         .x     (x_q),
         .care  (lane_care[l]),
         .val   (lane_val[l]),
         .omask (lane_omask[l]),
         .hit   (lane_hit[l])
      );
   end

   always_comb begin
      or_red  = '0;
      xor_red = '0;
      for (int l = 0; l < LANES; l++) begin
         or_red  = or_red | lane_hit[l];
         xor_red = xor_red ^ lane_hit[l];
      end
      acc_next = (acc_q | (or_red & ~mode)) ^ (xor_red & mode);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = EVAL;
         EVAL:    if (beat_q == LAST_BEAT) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         beat_q    <= '0;
         x_q       <= '0;
         acc_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_err_q <= cfg_fire & ~addr_ok;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  x_q    <= in_x;
                  acc_q  <= '0;
                  beat_q <= '0;
               end
            end
            EVAL: begin
               acc_q  <= acc_next;
               beat_q <= beat_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pla_cube_engine.sv
// Directed bench for pla_cube_engine: a default 32-cube instance and a
// 30-cube twin sharing the same stimulus to exercise out-of-range writes.
module tb_pla_cube_engine;

   logic        clk;
   logic        rst_n;
   logic        cfg_valid;
   logic [4:0]  cfg_addr;
   logic [19:0] cfg_care;
   logic [19:0] cfg_val;
   logic [0:0]  cfg_omask;
`ifdef PLA_EXOR_EN
   logic [0:0]  cfg_xor_mode;
`endif
   logic        in_valid;
   logic [19:0] in_x;
   logic        out_ready;

   logic        cfg_ready, cfg_err, in_ready, out_valid;
   logic [0:0]  out_y;
   logic        cfg_ready30, cfg_err30, in_ready30, out_valid30;
   logic [0:0]  out_y30;

   int total = 0;
   int bad   = 0;

   pla_cube_engine u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_addr     (cfg_addr),
      .cfg_care     (cfg_care),
      .cfg_val      (cfg_val),
      .cfg_omask    (cfg_omask),
`ifdef PLA_EXOR_EN
      .cfg_xor_mode (cfg_xor_mode),
`endif
      .cfg_err      (cfg_err),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_x         (in_x),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_y        (out_y)
   );

   pla_cube_engine #(.N_CUBES(30)) u_dut30 (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready30),
      .cfg_addr     (cfg_addr),
      .cfg_care     (cfg_care),
      .cfg_val      (cfg_val),
      .cfg_omask    (cfg_omask),
`ifdef PLA_EXOR_EN
      .cfg_xor_mode (cfg_xor_mode),
`endif
      .cfg_err      (cfg_err30),
      .in_valid     (in_valid),
      .in_ready     (in_ready30),
      .in_x         (in_x),
      .out_valid    (out_valid30),
      .out_ready    (out_ready),
      .out_y        (out_y30)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic writeCube(input logic [4:0] addr, input logic [19:0] care,
                            input logic [19:0] val, input logic [0:0] omask);
      cfg_addr  = addr;
      cfg_care  = care;
      cfg_val   = val;
      cfg_omask = omask;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   // Present one vector, scramble in_x once it is latched, and wait for the result.
   task automatic applyStimulus(input logic [19:0] x, output logic [0:0] y,
                                output logic [0:0] y30, output int lat);
      in_x     = x;
      in_valid = 1'b1;
      lat      = 0;
      y        = '0;
      y30      = '0;
      while (lat < 50) begin
         tick();
         lat++;
         in_valid  = 1'b0;
         cfg_valid = 1'b0;
         in_x      = ~x;
         if (out_valid) break;
      end
      if (!out_valid) begin
         checkOutput("result_timeout", 32'(out_valid), 32'd1);
      end
      y   = out_y;
      y30 = out_y30;
      checkOutput("twin_lockstep", 32'(out_valid30), 32'd1);
   endtask

   logic [0:0] y, y30;
   int         lat;

   initial begin
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_addr  = '0;
      cfg_care  = '0;
      cfg_val   = '0;
      cfg_omask = '0;
`ifdef PLA_EXOR_EN
      cfg_xor_mode = '0;
`endif
      in_valid  = 1'b0;
      in_x      = '0;
      out_ready = 1'b1;
      repeat (2) tick();

      checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
      checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_y",     32'(out_y),     32'd0);
      checkOutput("rst_cfg_err",   32'(cfg_err),   32'd0);
      rst_n = 1'b1;
      tick();

      // Empty table: zero result, NBEATS+1 cycles from in_valid to out_valid.
      applyStimulus(20'h0, y, y30, lat);
      checkOutput("empty_y",   32'(y),   32'd0);
      checkOutput("empty_lat", 32'(lat), 32'd9);
      tick();
      checkOutput("idle_after_done", 32'(in_ready), 32'd1);

      // Cube 0: !x13 & !x18.
      writeCube(5'd0, 20'h42000, 20'h0, 1'b1);
      applyStimulus(20'h0, y, y30, lat);
      checkOutput("c0_x0", 32'(y), 32'd1);
      tick();
      applyStimulus(20'h02000, y, y30, lat);
      checkOutput("c0_x13", 32'(y), 32'd0);
      tick();
      applyStimulus(20'h40000, y, y30, lat);
      checkOutput("c0_x18", 32'(y), 32'd0);
      tick();
      applyStimulus(20'h00020, y, y30, lat);
      checkOutput("c0_x5", 32'(y), 32'd1);
      tick();

      // Cube 5: x0 (positive literal).
      writeCube(5'd5, 20'h00001, 20'h00001, 1'b1);
      applyStimulus(20'h02001, y, y30, lat);
      checkOutput("c5_pos", 32'(y), 32'd1);
      tick();

      // Tautology at index 31: in range for 32 cubes, out of range for 30.
      writeCube(5'd31, 20'h0, 20'h0, 1'b1);
      checkOutput("err30_pulse", 32'(cfg_err30), 32'd1);
      checkOutput("err32_quiet", 32'(cfg_err),   32'd0);
      tick();
      checkOutput("err30_one_cycle", 32'(cfg_err30), 32'd0);
      applyStimulus(20'h02000, y, y30, lat);
      checkOutput("taut31_y",   32'(y),   32'd1);
      checkOutput("oob30_y",    32'(y30), 32'd0);
      checkOutput("taut31_lat", 32'(lat), 32'd9);
      tick();

      // Back-pressure: result held while out_ready is low.
      out_ready = 1'b0;
      applyStimulus(20'h0, y, y30, lat);
      checkOutput("stall_y", 32'(y), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("stall_valid", 32'(out_valid), 32'd1);
         checkOutput("stall_hold_y", 32'(out_y),   32'd1);
         checkOutput("stall_in_rdy", 32'(in_ready), 32'd0);
         checkOutput("stall_cfg_rdy", 32'(cfg_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      checkOutput("release_valid", 32'(out_valid), 32'd0);
      checkOutput("release_in_rdy", 32'(in_ready), 32'd1);

      // Reset in the middle of evaluation, at beat 3.
      in_x     = 20'h0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      checkOutput("mid_eval_busy", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_in_rdy", 32'(in_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("post_rst_in_rdy", 32'(in_ready), 32'd1);
      applyStimulus(20'h0, y, y30, lat);
      checkOutput("table_cleared", 32'(y), 32'd0);
      tick();

      // Config write and vector accept in the same cycle: new cube is used.
      cfg_addr  = 5'd2;
      cfg_care  = 20'h0;
      cfg_val   = 20'h0;
      cfg_omask = 1'b1;
      cfg_valid = 1'b1;
      applyStimulus(20'h0, y, y30, lat);
      checkOutput("same_cycle_y",   32'(y),   32'd1);
      checkOutput("same_cycle_y30", 32'(y30), 32'd1);
      tick();

`ifdef PLA_EXOR_EN
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      cfg_xor_mode = 1'b1;
      writeCube(5'd1, 20'h0, 20'h0, 1'b1);
      writeCube(5'd2, 20'h0, 20'h0, 1'b1);
      applyStimulus(20'h0, y, y30, lat);
      checkOutput("xor_two_match", 32'(y), 32'd0);
      tick();
      writeCube(5'd2, 20'h00001, 20'h00001, 1'b1);
      applyStimulus(20'h0, y, y30, lat);
      checkOutput("xor_one_match", 32'(y), 32'd1);
      tick();
      applyStimulus(20'h00001, y, y30, lat);
      checkOutput("xor_two_again", 32'(y), 32'd0);
      tick();
      writeCube(5'd13, 20'h0, 20'h0, 1'b1);
      applyStimulus(20'h00001, y, y30, lat);
      checkOutput("xor_three_beats", 32'(y), 32'd1);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
